timer_scheduler: RTL and testbench

// - Shares one seconds prescaler between NCH independent countdown channels.
// - Each requester owns one channel and arms it with a seconds count.
// - The channel-load path is a single shared write port. A round-robin arbiter grants it.
// - Sits beside the VGA timing/timer logic and supplies timeouts to display FSMs.

---
 rtl/timer_scheduler.sv | 125 ++++++++++++
 tb/tb_timer_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_scheduler.sv
// Shared-prescaler countdown timers: NCH channels armed through one round-robin
// arbitrated load port, each counting whole seconds down to an expire pulse.
module timer_scheduler #(
    parameter int NCH      = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int SECW     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*SECW-1:0]     req_secs,
    input  logic [NCH-1:0]          cancel,
    input  logic [$clog2(NCH)-1:0]  mon_sel,
    output logic [NCH-1:0]          grant,
    output logic [NCH-1:0]          busy,
    output logic [NCH-1:0]          expire,
    output logic                    tick,
    output logic [SECW-1:0]         mon_secs
);

    localparam int PW = $clog2(NCH);
    localparam int AW = $clog2(TICK_DIV);
    localparam logic [AW-1:0] ACC_LAST = AW'(TICK_DIV - 1);

    typedef enum logic {IDLE = 1'b0, RUNNING = 1'b1} ch_state_e;

    ch_state_e       state_q [NCH];
    ch_state_e       state_d [NCH];
    logic [SECW-1:0] cnt_q   [NCH];
    logic [SECW-1:0] cnt_d   [NCH];
    logic [NCH-1:0]  grant_d;
    logic [NCH-1:0]  expire_d;
    logic [NCH-1:0]  eligible;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;
    logic [PW-1:0]   win_idx;
    logic            win_valid;
    logic [AW-1:0]   accum;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            accum <= '0;
            tick  <= 1'b0;
        end else if (accum == ACC_LAST) begin
            accum <= '0;
            tick  <= 1'b1;
        end else begin
            accum <= accum + AW'(1);
            tick  <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state_q[i] == RUNNING);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        eligible  = req & ~busy & ~cancel;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!win_valid && eligible[(int'(ptr_q) + k) % NCH]) begin
                win_valid = 1'b1;
                win_idx   = PW'((int'(ptr_q) + k) % NCH);
            end
        end

        ptr_d = ptr_q;
        if (win_valid) begin
            ptr_d = (win_idx == PW'(NCH - 1)) ? '0 : win_idx + PW'(1);
        end

        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            grant_d[i]  = 1'b0;
            expire_d[i] = 1'b0;
            if (state_q[i] == RUNNING) begin
                // Cancel outranks both a zero-length load and a final tick.
                if (cancel[i]) begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end else if (cnt_q[i] == '0 || (tick && cnt_q[i] == SECW'(1))) begin
                    state_d[i]  = IDLE;
                    cnt_d[i]    = '0;
                    expire_d[i] = 1'b1;
                end else if (tick) begin
                    cnt_d[i] = cnt_q[i] - SECW'(1);
                end
            end else if (win_valid && win_idx == PW'(i)) begin
                state_d[i] = RUNNING;
                cnt_d[i]   = req_secs[i*SECW +: SECW];
                grant_d[i] = 1'b1;
            end
        end
    end

    // NOTE: the count array is a handful of flops, not a RAM, so it is reset with everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q    <= '0;
            grant    <= '0;
            expire   <= '0;
            mon_secs <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            grant    <= grant_d;
            expire   <= expire_d;
            mon_secs <= (int'(mon_sel) < NCH) ? cnt_q[mon_sel] : '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: a time-based channel model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_timer_scheduler;

    localparam int TD = 10;
    localparam int N  = 4;
    localparam int SW = 8;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*SW-1:0] req_secs = '0;
    logic [N-1:0]    cancel = '0;
    logic [1:0]      mon_sel = '0;
    logic [N-1:0]    grant;
    logic [N-1:0]    busy;
    logic [N-1:0]    expire;
    logic            tick;
    logic [SW-1:0]   mon_secs;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit auto_drop = 1'b1;

    timer_scheduler #(.NCH(N), .TICK_DIV(TD), .SECW(SW)) dut (
        .clock(clock), .reset(reset), .req(req), .req_secs(req_secs),
        .cancel(cancel), .mon_sel(mon_sel), .grant(grant), .busy(busy),
        .expire(expire), .tick(tick), .mon_secs(mon_secs)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a channel holds "seconds remaining"; ticks land on every multiple of TD
    // cycles since reset; a running channel expires once its remaining time is zero.
    bit            m_valid = 1'b0;
    bit            m_busy [N];
    int            m_rem  [N];
    int            m_ptr;
    int            mcyc;
    int            w;
    bit            ticked;
    logic [N-1:0]  m_grant;
    logic [N-1:0]  m_expire;
    logic          m_tick;
    logic [SW-1:0] m_mon;

    initial forever begin
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 1'b0;
                m_rem[i]  = 0;
            end
            m_ptr = 0; mcyc = 0; m_grant = '0; m_expire = '0; m_tick = 1'b0; m_mon = '0;
            m_valid = 1'b1;
        end else begin
            ticked = (mcyc > 0) && (mcyc % TD == 0);
            m_mon  = (int'(mon_sel) < N) ? SW'(m_rem[mon_sel]) : '0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N] && !m_busy[(m_ptr + k) % N]
                    && !cancel[(m_ptr + k) % N])
                    w = (m_ptr + k) % N;
            end
            m_grant = '0; m_expire = '0;
            for (int i = 0; i < N; i++) begin
                if (m_busy[i]) begin
                    if (cancel[i]) begin
                        m_busy[i] = 1'b0;
                        m_rem[i]  = 0;
                    end else begin
                        if (ticked && m_rem[i] > 0) m_rem[i] = m_rem[i] - 1;
                        if (m_rem[i] == 0) begin
                            m_busy[i]   = 1'b0;
                            m_expire[i] = 1'b1;
                        end
                    end
                end else if (i == w) begin
                    m_busy[i]  = 1'b1;
                    m_rem[i]   = int'(req_secs[i*SW +: SW]);
                    m_grant[i] = 1'b1;
                end
            end
            if (w >= 0) m_ptr = (w + 1) % N;
            mcyc++;
            m_tick = (mcyc % TD == 0);
        end
    end

    initial forever begin
        @(negedge clock);
        if (m_valid) begin
            logic [N-1:0] mb;
            for (int i = 0; i < N; i++) mb[i] = m_busy[i];
            check("cmp grant", 32'(grant), 32'(m_grant));
            check("cmp busy", 32'(busy), 32'(mb));
            check("cmp expire", 32'(expire), 32'(m_expire));
            check("cmp tick", 32'(tick), 32'(m_tick));
            check("cmp mon_secs", 32'(mon_secs), 32'(m_mon));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (auto_drop) req = req & ~grant;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic restart();
        req = '0; cancel = '0; req_secs = '0; auto_drop = 1'b1;
        pulse_reset();
    endtask

    initial begin
        int n_exp;
        int first_tick;

        // Reset state and a single 3-second timer on channel 0.
        restart();
        check("rst grant", 32'(grant), 0);
        check("rst busy", 32'(busy), 0);
        check("rst expire", 32'(expire), 0);
        check("rst tick", 32'(tick), 0);
        check("rst mon", 32'(mon_secs), 0);
        mon_sel = 2'd0;
        go_to(2); req[0] = 1'b1; req_secs[7:0] = 8'd3;
        go_to(3); check("t1 grant@3", 32'(grant), 32'h1);
        go_to(4); check("t1 mon@4", 32'(mon_secs), 3);
        go_to(10); check("t1 tick@10", 32'(tick), 1);
        go_to(12); check("t1 mon@12", 32'(mon_secs), 2);
        go_to(30); check("t1 busy@30", 32'(busy[0]), 1);
        go_to(31); check("t1 expire@31", 32'(expire), 32'h1);
        check("t1 busy@31", 32'(busy[0]), 0);
        go_to(32); check("t1 expire@32", 32'(expire), 0);

        // All four request together: grants in index order, pointer wraps to 0.
        restart();
        go_to(1); req = 4'hF; req_secs = {4{8'd5}};
        for (int k = 0; k < 4; k++) begin
            go_to(2 + k);
            check("t2 grant order", 32'(grant), 32'h1 << k);
        end
        go_to(6); cancel = 4'hF;
        go_to(7); cancel = '0;
        check("t2 busy after cancel", 32'(busy), 0);
        check("t2 no expire on cancel", 32'(expire), 0);
        req = 4'hF;
        go_to(8); check("t2 pointer back at 0", 32'(grant), 32'h1);
        go_to(9); check("t2 next grant 1", 32'(grant), 32'h2);

        // Two persistent zero-length requesters alternate.
        restart();
        auto_drop = 1'b0;
        go_to(1); req = 4'b0101; req_secs = '0;
        for (int k = 0; k < 6; k++) begin
            go_to(2 + k);
            check("t3 alternate", 32'(grant), (k % 2 == 0) ? 32'h1 : 32'h4);
        end
        req = '0; auto_drop = 1'b1;

        // Zero-length timer granted on a tick cycle expires the next cycle.
        restart();
        mon_sel = 2'd1;
        go_to(9); req[1] = 1'b1; req_secs[15:8] = 8'd0;
        go_to(10); check("t4 grant@10", 32'(grant), 32'h2);
        check("t4 tick@10", 32'(tick), 1);
        go_to(11); check("t4 expire@11", 32'(expire), 32'h2);
        check("t4 busy@11", 32'(busy[1]), 0);
        go_to(12); check("t4 expire@12", 32'(expire), 0);
        check("t4 mon", 32'(mon_secs), 0);

        // Cancel on the same cycle as the final tick suppresses expire.
        restart();
        mon_sel = 2'd3;
        go_to(2); req[3] = 1'b1; req_secs[31:24] = 8'd1;
        go_to(3); check("t5 grant@3", 32'(grant), 32'h8);
        go_to(10); cancel[3] = 1'b1;
        check("t5 tick@10", 32'(tick), 1);
        go_to(11); cancel = '0;
        check("t5 busy@11", 32'(busy[3]), 0);
        n_exp = 0;
        while (cyc < 30) begin
            if (expire[3]) n_exp++;
            step();
        end
        check("t5 no expire", 32'(n_exp), 0);

        // Reset mid-run drops both channels with no late expire.
        restart();
        mon_sel = 2'd0;
        go_to(1); req = 4'b0011; req_secs[15:0] = {8'd3, 8'd3};
        go_to(15); check("t6 busy before reset", 32'(busy), 32'h3);
        pulse_reset();
        check("t6 rst grant", 32'(grant), 0);
        check("t6 rst busy", 32'(busy), 0);
        check("t6 rst expire", 32'(expire), 0);
        check("t6 rst tick", 32'(tick), 0);
        check("t6 rst mon", 32'(mon_secs), 0);
        n_exp = 0;
        first_tick = -1;
        while (cyc < 5 * TD) begin
            step();
            if (expire != '0) n_exp++;
            if (tick && first_tick < 0) first_tick = cyc;
        end
        check("t6 no late expire", 32'(n_exp), 0);
        check("t6 first tick", 32'(first_tick), TD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
